// File: rtl/cfg_ls_stream_sel_ctx_if.sv
// Configuration write bus for cfg_ls_stream_sel_ctx: one packed L/S context
// image per cycle plus the reject pulse returned to the writer.
interface cfg_ls_stream_sel_ctx_if #(
    parameter int N_BANKS_GROUP        = 2,
    parameter int N_BANKS_PER_STREAM   = 2,
    parameter int LOG_N_AGE_PER_STREAM = 2,
    parameter int LOG_N_PE_PER_GROUP   = 2,
    parameter int N_CTX                = 4,
    parameter int LOG_N_CTX            = $clog2(N_CTX),
    parameter int NF                   = N_BANKS_GROUP * N_BANKS_PER_STREAM
);
    logic                               cfg_we_i;
    logic [LOG_N_CTX-1:0]               cfg_ctx_i;
    logic [NF*LOG_N_AGE_PER_STREAM-1:0] cfg_l_sel_i;
    logic [NF*LOG_N_PE_PER_GROUP-1:0]   cfg_s_sel_i;
    logic                               cfg_err_o;

    modport master (
        output cfg_we_i, cfg_ctx_i, cfg_l_sel_i, cfg_s_sel_i,
        input  cfg_err_o
    );

    modport slave (
        input  cfg_we_i, cfg_ctx_i, cfg_l_sel_i, cfg_s_sel_i,
        output cfg_err_o
    );
endinterface

// File: rtl/cfg_ls_stream_sel_ctx.sv
// Multi-context stream-select configuration bank for the L/S crossbars.
// Optional macro CFG_LS_STREAM_SEL_LOCK_EN: reject writes to the live active context.
module cfg_ls_stream_sel_ctx #(
    parameter int N_BANKS_GROUP        = 2,
    parameter int N_BANKS_PER_STREAM   = 2,
    parameter int LOG_N_AGE_PER_STREAM = 2,
    parameter int LOG_N_PE_PER_GROUP   = 2,
    parameter int N_CTX                = 4,
    parameter int LOG_N_CTX            = $clog2(N_CTX),
    parameter int NF                   = N_BANKS_GROUP * N_BANKS_PER_STREAM
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    cfg_ls_stream_sel_ctx_if.slave cfg,
    input  logic                 ctx_clear_i,
    input  logic                 ctx_start_i,
    input  logic [LOG_N_CTX-1:0] ctx_start_idx_i,
    input  logic [LOG_N_CTX-1:0] ctx_last_i,
    input  logic                 ctx_next_i,
    output logic                 ctx_err_o,
    output logic                 ctx_wrap_o,
    output logic [LOG_N_CTX-1:0] active_ctx_o,
    output logic                 sel_valid_o,
    output logic [N_BANKS_GROUP-1:0][N_BANKS_PER_STREAM-1:0][LOG_N_AGE_PER_STREAM-1:0] l_stream_sel_o,
    output logic [N_BANKS_GROUP-1:0][N_BANKS_PER_STREAM-1:0][LOG_N_PE_PER_GROUP-1:0]   s_stream_sel_o
);
    localparam int LW = NF * LOG_N_AGE_PER_STREAM;
    localparam int SW = NF * LOG_N_PE_PER_GROUP;

    logic [LW-1:0]        l_mem [N_CTX];
    logic [SW-1:0]        s_mem [N_CTX];
    logic [N_CTX-1:0]     valid_q;
    logic [LOG_N_CTX-1:0] start_q;

    logic                 lock_hit;
    logic                 wr_ok;
    logic                 cfg_err_n;
    logic [N_CTX-1:0]     valid_n;
    logic [LOG_N_CTX-1:0] start_n;
    logic [LOG_N_CTX-1:0] active_n;
    logic [LOG_N_CTX-1:0] cand;
    logic                 at_last;
    logic                 ctx_err_n;
    logic                 wrap_n;
    logic [LW-1:0]        rd_l;
    logic [SW-1:0]        rd_s;

    always_comb begin
        lock_hit = 1'b0;
`ifdef CFG_LS_STREAM_SEL_LOCK_EN
        lock_hit = cfg.cfg_we_i && (cfg.cfg_ctx_i == active_ctx_o) && sel_valid_o;
`endif
        wr_ok     = cfg.cfg_we_i && !ctx_clear_i && !lock_hit;
        cfg_err_n = (cfg.cfg_we_i && ctx_clear_i) || lock_hit;

        valid_n = valid_q;
        if (wr_ok)
            valid_n[cfg.cfg_ctx_i] = 1'b1;
        if (ctx_clear_i)
            valid_n = '0;

        // Candidate is judged against valid bits after this cycle's write.
        at_last   = (active_ctx_o == ctx_last_i);
        cand      = at_last ? start_q : active_ctx_o + 1'b1;
        start_n   = start_q;
        active_n  = active_ctx_o;
        ctx_err_n = 1'b0;
        wrap_n    = 1'b0;
        if (ctx_clear_i) begin
            active_n = '0;
        end else if (ctx_start_i) begin
            active_n  = ctx_start_idx_i;
            start_n   = ctx_start_idx_i;
            ctx_err_n = !valid_n[ctx_start_idx_i];
        end else if (ctx_next_i) begin
            if (valid_n[cand]) begin
                active_n = cand;
                wrap_n   = at_last;
            end else begin
                ctx_err_n = 1'b1;
            end
        end

        // Write-through so a same-cycle write to the next active context is seen.
        rd_l = '0;
        rd_s = '0;
        if (valid_n[active_n]) begin
            rd_l = (wr_ok && cfg.cfg_ctx_i == active_n) ? cfg.cfg_l_sel_i : l_mem[active_n];
            rd_s = (wr_ok && cfg.cfg_ctx_i == active_n) ? cfg.cfg_s_sel_i : s_mem[active_n];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < N_CTX; i++) begin
                l_mem[i] <= '0;
                s_mem[i] <= '0;
            end
            valid_q        <= '0;
            start_q        <= '0;
            active_ctx_o   <= '0;
            sel_valid_o    <= 1'b0;
            ctx_err_o      <= 1'b0;
            ctx_wrap_o     <= 1'b0;
            cfg.cfg_err_o  <= 1'b0;
            l_stream_sel_o <= '0;
            s_stream_sel_o <= '0;
        end else begin
            if (wr_ok) begin
                l_mem[cfg.cfg_ctx_i] <= cfg.cfg_l_sel_i;
                s_mem[cfg.cfg_ctx_i] <= cfg.cfg_s_sel_i;
            end
            valid_q       <= valid_n;
            start_q       <= start_n;
            active_ctx_o  <= active_n;
            sel_valid_o   <= valid_n[active_n];
            ctx_err_o     <= ctx_err_n;
            ctx_wrap_o    <= wrap_n;
            cfg.cfg_err_o <= cfg_err_n;
            // Packed field f = j*N_BANKS_PER_STREAM+k lands directly on [j][k].
            l_stream_sel_o <= rd_l;
            s_stream_sel_o <= rd_s;
        end
    end
endmodule

// File: tb/tb_cfg_ls_stream_sel_ctx.sv
// Directed bench for cfg_ls_stream_sel_ctx; lock expectations follow CFG_LS_STREAM_SEL_LOCK_EN.
module tb_cfg_ls_stream_sel_ctx;
    logic       clk = 1'b0;
    logic       rst_n_i;
    logic       ctx_clear_i, ctx_start_i, ctx_next_i;
    logic [1:0] ctx_start_idx_i, ctx_last_i;
    logic       ctx_err_o, ctx_wrap_o, sel_valid_o;
    logic [1:0] active_ctx_o;
    logic [1:0][1:0][1:0] l_stream_sel_o, s_stream_sel_o;
    int checks = 0;
    int errors = 0;

    cfg_ls_stream_sel_ctx_if bus ();

    cfg_ls_stream_sel_ctx dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .cfg(bus.slave),
        .ctx_clear_i(ctx_clear_i), .ctx_start_i(ctx_start_i),
        .ctx_start_idx_i(ctx_start_idx_i), .ctx_last_i(ctx_last_i),
        .ctx_next_i(ctx_next_i), .ctx_err_o(ctx_err_o), .ctx_wrap_o(ctx_wrap_o),
        .active_ctx_o(active_ctx_o), .sel_valid_o(sel_valid_o),
        .l_stream_sel_o(l_stream_sel_o), .s_stream_sel_o(s_stream_sel_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] ctx, input logic [7:0] l, input logic [7:0] s);
        bus.cfg_we_i    = 1'b1;
        bus.cfg_ctx_i   = ctx;
        bus.cfg_l_sel_i = l;
        bus.cfg_s_sel_i = s;
    endtask

    initial begin
        rst_n_i = 1'b0;
        bus.cfg_we_i = 1'b0; bus.cfg_ctx_i = '0; bus.cfg_l_sel_i = '0; bus.cfg_s_sel_i = '0;
        ctx_clear_i = 0; ctx_start_i = 0; ctx_next_i = 0;
        ctx_start_idx_i = 0; ctx_last_i = 2'd2;
        #12;
        check("rst_active", active_ctx_o, 0);
        check("rst_valid", sel_valid_o, 0);
        check("rst_l", l_stream_sel_o, 0);
        check("rst_cfg_err", bus.cfg_err_o, 0);
        @(negedge clk);
        rst_n_i = 1'b1;

        // Unpacking of context 0
        wr(2'd0, 8'hE4, 8'h1B);
        step();
        bus.cfg_we_i = 1'b0;
        check("l00", l_stream_sel_o[0][0], 0);
        check("l01", l_stream_sel_o[0][1], 1);
        check("l10", l_stream_sel_o[1][0], 2);
        check("l11", l_stream_sel_o[1][1], 3);
        check("s00", s_stream_sel_o[0][0], 3);
        check("s11", s_stream_sel_o[1][1], 0);
        check("valid0", sel_valid_o, 1);

        // Next into invalid ctx1 is refused
        ctx_next_i = 1'b1;
        step();
        ctx_next_i = 1'b0;
        check("nx_inv_err", ctx_err_o, 1);
        check("nx_inv_active", active_ctx_o, 0);
        check("nx_inv_l", l_stream_sel_o, 8'hE4);
        check("nx_inv_wrap", ctx_wrap_o, 0);
        step();
        check("nx_inv_err_pulse", ctx_err_o, 0);

        // Same-cycle write of ctx1 and next into it
        wr(2'd1, 8'h55, 8'h99);
        ctx_next_i = 1'b1;
        step();
        bus.cfg_we_i = 1'b0; ctx_next_i = 1'b0;
        check("wn_active", active_ctx_o, 1);
        check("wn_l", l_stream_sel_o, 8'h55);
        check("wn_s", s_stream_sel_o, 8'h99);
        check("wn_err", ctx_err_o, 0);

        // Start/next/wrap over ctx1..ctx2
        wr(2'd2, 8'h3C, 8'hC3);
        step();
        bus.cfg_we_i = 1'b0;
        ctx_start_idx_i = 2'd1; ctx_start_i = 1'b1;
        step();
        ctx_start_i = 1'b0;
        check("st_active", active_ctx_o, 1);
        check("st_err", ctx_err_o, 0);
        ctx_next_i = 1'b1;
        step();
        check("n1_active", active_ctx_o, 2);
        check("n1_l", l_stream_sel_o, 8'h3C);
        check("n1_wrap", ctx_wrap_o, 0);
        step();
        ctx_next_i = 1'b0;
        check("n2_active", active_ctx_o, 1);
        check("n2_wrap", ctx_wrap_o, 1);
        check("n2_l", l_stream_sel_o, 8'h55);
        step();
        check("wrap_pulse", ctx_wrap_o, 0);

        // Write the live active context
        wr(2'd1, 8'h0F, 8'hF0);
        step();
        bus.cfg_we_i = 1'b0;
`ifdef CFG_LS_STREAM_SEL_LOCK_EN
        check("lock_err", bus.cfg_err_o, 1);
        check("lock_l", l_stream_sel_o, 8'h55);
`else
        check("live_err", bus.cfg_err_o, 0);
        check("live_l", l_stream_sel_o, 8'h0F);
        check("live_s", s_stream_sel_o, 8'hF0);
`endif
        wr(2'd3, 8'hA5, 8'h5A);
        step();
        bus.cfg_we_i = 1'b0;
        check("shadow_err", bus.cfg_err_o, 0);

        // Clear dominates write and next
        wr(2'd2, 8'hFF, 8'hFF);
        ctx_clear_i = 1'b1; ctx_next_i = 1'b1;
        step();
        bus.cfg_we_i = 1'b0; ctx_clear_i = 1'b0; ctx_next_i = 1'b0;
        check("clr_active", active_ctx_o, 0);
        check("clr_valid", sel_valid_o, 0);
        check("clr_l", l_stream_sel_o, 0);
        check("clr_s", s_stream_sel_o, 0);
        check("clr_cfg_err", bus.cfg_err_o, 1);
        step();
        check("clr_cfg_err_pulse", bus.cfg_err_o, 0);

        // Start into an invalid context
        ctx_start_idx_i = 2'd2; ctx_start_i = 1'b1;
        step();
        ctx_start_i = 1'b0;
        check("sti_active", active_ctx_o, 2);
        check("sti_valid", sel_valid_o, 0);
        check("sti_err", ctx_err_o, 1);
        check("sti_l", l_stream_sel_o, 0);

        // Fill active ctx2 then reset asynchronously mid-cycle
        wr(2'd2, 8'h12, 8'h34);
        step();
        bus.cfg_we_i = 1'b0;
        check("w2_valid", sel_valid_o, 1);
        check("w2_l", l_stream_sel_o, 8'h12);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("arst_l", l_stream_sel_o, 0);
        check("arst_s", s_stream_sel_o, 0);
        check("arst_active", active_ctx_o, 0);
        check("arst_valid", sel_valid_o, 0);
        @(negedge clk);
        rst_n_i = 1'b1;
        ctx_start_idx_i = 2'd2; ctx_start_i = 1'b1;
        step();
        ctx_start_i = 1'b0;
        check("post_rst_valid", sel_valid_o, 0);
        check("post_rst_l", l_stream_sel_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
